// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
// Latency: none, signal bundle only.
// Backpressure: memory holds off completion by withholding mem_ack.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores on the data-memory port, formats load data, fills MEM->WB.
// Latency: 1 cycle for non-memory ops and misaligned aborts, 2+ cycles for memory accesses.
// Backpressure: m_stall holds upstream from request launch until mem_ack or timeout abort.
module memory_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic        m_mem_byte,
    input  logic        m_reg_write,
    input  logic        m_mem_to_reg,
    input  logic [5:0]  m_dst_reg,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_store_data,
    output logic        m_stall,
    memory_stage_if.master dmem,
    output logic        w_valid,
    output logic        w_reg_write,
    output logic [5:0]  w_dst_reg,
    output logic [31:0] w_result,
    output logic [1:0]  w_exc
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] counter;

    // Request context kept for formatting the writeback once the access completes.
    logic [5:0]    l_dst;
    logic          l_reg_write;
    logic          l_mem_to_reg;
    logic          l_byte;
    logic          l_we;
    logic [31:0]   l_addr;

    logic          is_mem;
    logic          misaligned;
    logic          start;
    logic          busy;
    logic          timeout;
    logic [7:0]    rd_lane;

    assign is_mem     = m_valid & (m_mem_read | m_mem_write);
    assign misaligned = is_mem & ~m_mem_byte & (m_alu_result[1:0] != 2'b00);
    assign start      = (state == ST_IDLE) & is_mem & ~misaligned;
    assign busy       = (state == ST_BUSY);
    assign timeout    = busy & ~dmem.mem_ack & (counter == CW'(TIMEOUT - 1));
    // Gated by reset so the stall drops the instant reset asserts, whatever upstream presents.
    assign m_stall    = reset & (start | (busy & ~dmem.mem_ack & ~timeout));

    // Select the little-endian byte lane addressed by the latched low address bits.
    always_comb begin
        rd_lane = dmem.mem_rdata[7:0];
        case (l_addr[1:0])
            2'd0:    rd_lane = dmem.mem_rdata[7:0];
            2'd1:    rd_lane = dmem.mem_rdata[15:8];
            2'd2:    rd_lane = dmem.mem_rdata[23:16];
            default: rd_lane = dmem.mem_rdata[31:24];
        endcase
    end

    // Stage control: launch requests, wait for ack or timeout, and load the WB register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            counter        <= '0;
            dmem.mem_req   <= 1'b0;
            dmem.mem_we    <= 1'b0;
            dmem.mem_addr  <= '0;
            dmem.mem_be    <= '0;
            dmem.mem_wdata <= '0;
            l_dst          <= '0;
            l_reg_write    <= 1'b0;
            l_mem_to_reg   <= 1'b0;
            l_byte         <= 1'b0;
            l_we           <= 1'b0;
            l_addr         <= '0;
            w_valid        <= 1'b0;
            w_reg_write    <= 1'b0;
            w_dst_reg      <= '0;
            w_result       <= '0;
            w_exc          <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!m_valid) begin
                        w_valid <= 1'b0;
                    end else if (!is_mem) begin
                        w_valid     <= 1'b1;
                        w_reg_write <= m_reg_write;
                        w_dst_reg   <= m_dst_reg;
                        w_result    <= m_alu_result;
                        w_exc       <= 2'b00;
                    end else if (misaligned) begin
                        w_valid     <= 1'b1;
                        w_reg_write <= 1'b0;
                        w_exc       <= 2'b01;
                    end else begin
                        // A simultaneous read+write is handled as a read.
                        w_valid        <= 1'b0;
                        dmem.mem_req   <= 1'b1;
                        dmem.mem_we    <= m_mem_write & ~m_mem_read;
                        dmem.mem_addr  <= {m_alu_result[31:2], 2'b00};
                        dmem.mem_be    <= m_mem_byte ? (4'b0001 << m_alu_result[1:0]) : 4'b1111;
                        dmem.mem_wdata <= m_mem_byte ? {4{m_store_data[7:0]}} : m_store_data;
                        counter        <= '0;
                        l_dst          <= m_dst_reg;
                        l_reg_write    <= m_reg_write;
                        l_mem_to_reg   <= m_mem_to_reg;
                        l_byte         <= m_mem_byte;
                        l_we           <= m_mem_write & ~m_mem_read;
                        l_addr         <= m_alu_result;
                        state          <= ST_BUSY;
                    end
                end
                default: begin
                    if (dmem.mem_ack) begin
                        dmem.mem_req <= 1'b0;
                        w_valid      <= 1'b1;
                        w_dst_reg    <= l_dst;
                        w_exc        <= 2'b00;
                        w_reg_write  <= l_reg_write & ~l_we;
                        w_result     <= l_mem_to_reg
                                        ? (l_byte ? {24'b0, rd_lane} : dmem.mem_rdata)
                                        : l_addr;
                        state        <= ST_IDLE;
                    end else if (timeout) begin
                        dmem.mem_req <= 1'b0;
                        w_valid      <= 1'b1;
                        w_reg_write  <= 1'b0;
                        w_exc        <= 2'b10;
                        state        <= ST_IDLE;
                    end else begin
                        w_valid <= 1'b0;
                        counter <= counter + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
